// File: rtl/bus_mailbox_device.sv
// Bus mailbox device: a self-decoded 16-byte register window that fronts a
// TX FIFO (host to peripheral) and an RX FIFO (peripheral to host).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   address, data_write,         bus request from the hub
//   write_mask, ren, wen
//   data_read, ready             registered response (data is 0 unless ready)
//   active                       combinational window decode back to the hub
//   tx_valid, tx_data, tx_pop    TX FIFO head and consume strobe
//   rx_push, rx_data, rx_full    RX FIFO push side
//   irq                          registered interrupt
module bus_mailbox_device #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] data_write,
    input  logic [3:0]  write_mask,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] data_read,
    output logic        ready,
    output logic        active,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_pop,
    input  logic        rx_push,
    input  logic [31:0] rx_data,
    output logic        rx_full,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [3:0]    wait_cnt;
    logic [1:0]    off_q;
    logic [31:0]   wdata_q;
    logic [3:0]    mask_q;
    logic          write_q;
    logic [2:0]    ctrl;
    logic          tx_ovf, rx_unf, rx_ovf;

    logic          req, commit;
    logic [1:0]    t_off;
    logic [31:0]   t_wdata, t_wdata_m, rdata_c, status;
    logic [3:0]    t_mask;
    logic          t_write;

    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [CW-1:0] tx_wr, tx_rd, rx_wr, rx_rd, tx_count, rx_count;
    logic          tx_full, tx_empty, rx_empty;
    logic          tx_push_req, tx_push, tx_pop_eff, tx_ovf_set;
    logic          rx_rd_req, rx_pop, rx_unf_set, rx_push_ok, rx_ovf_set;
    logic          sts_wr, ctrl_wr;
    logic          unused_addr;

    assign unused_addr = ^address[1:0];
    assign active      = (address[31:4] == BASE_ADDR[31:4]);
    assign req         = ren | wen;

    // In IDLE the transaction is taken from the live bus so WAIT_STATES=0 works
    assign t_off   = (state == IDLE) ? address[3:2] : off_q;
    assign t_wdata = (state == IDLE) ? data_write   : wdata_q;
    assign t_mask  = (state == IDLE) ? write_mask   : mask_q;
    assign t_write = (state == IDLE) ? wen          : write_q;

    // Side effects happen on the single edge that enters RESP
    assign commit = (state_next == RESP);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req && active) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT: begin
                if (!req)                      state_next = IDLE;
                else if (wait_cnt == WS_LAST)  state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Wait counter and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (state == IDLE && req && active) begin
                off_q   <= address[3:2];
                wdata_q <= data_write;
                mask_q  <= write_mask;
                write_q <= wen;
            end
        end
    end

    // Masked-off bytes are stored as zero
    always_comb begin
        t_wdata_m = '0;
        for (int i = 0; i < 4; i++)
            if (t_mask[i]) t_wdata_m[8*i +: 8] = t_wdata[8*i +: 8];
    end

    assign tx_count = tx_wr - tx_rd;
    assign rx_count = rx_wr - rx_rd;
    assign tx_empty = (tx_count == '0);
    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == CW'(DEPTH));
    assign rx_full  = (rx_count == CW'(DEPTH));
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rd[AW-1:0]];

    // A pop in the same cycle frees a slot for a push into a full FIFO
    assign tx_pop_eff  = tx_pop & ~tx_empty;
    assign tx_push_req = commit & t_write & (t_off == 2'd0) & (|t_mask);
    assign tx_push     = tx_push_req & (~tx_full | tx_pop_eff);
    assign tx_ovf_set  = tx_push_req & tx_full & ~tx_pop_eff;

    assign rx_rd_req   = commit & ~t_write & (t_off == 2'd1);
    assign rx_pop      = rx_rd_req & ~rx_empty;
    assign rx_unf_set  = rx_rd_req & rx_empty;
    assign rx_push_ok  = rx_push & (~rx_full | rx_pop);
    assign rx_ovf_set  = rx_push & rx_full & ~rx_pop;

    assign sts_wr  = commit & t_write & (t_off == 2'd2) & t_mask[0];
    assign ctrl_wr = commit & t_write & (t_off == 2'd3) & t_mask[0];

    assign status = {8'h00, 8'(rx_count), 8'(tx_count), 1'b0,
                     rx_ovf, rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

    // Read data mux
    always_comb begin
        rdata_c = '0;
        case (t_off)
            2'd1:    rdata_c = rx_empty ? 32'h0 : rx_mem[rx_rd[AW-1:0]];
            2'd2:    rdata_c = status;
            2'd3:    rdata_c = {29'h0, ctrl};
            default: rdata_c = '0;
        endcase
    end

    // FIFO storage (no reset needed; pointers define validity)
    always_ff @(posedge clk) begin
        if (tx_push)    tx_mem[tx_wr[AW-1:0]] <= t_wdata_m;
        if (rx_push_ok) rx_mem[rx_wr[AW-1:0]] <= rx_data;
    end

    // Pointers, flags, control and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr     <= '0;
            tx_rd     <= '0;
            rx_wr     <= '0;
            rx_rd     <= '0;
            tx_ovf    <= 1'b0;
            rx_unf    <= 1'b0;
            rx_ovf    <= 1'b0;
            ctrl      <= '0;
            data_read <= '0;
            ready     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (tx_push)    tx_wr <= tx_wr + CW'(1);
            if (tx_pop_eff) tx_rd <= tx_rd + CW'(1);
            if (rx_push_ok) rx_wr <= rx_wr + CW'(1);
            if (rx_pop)     rx_rd <= rx_rd + CW'(1);
            // A new error in the same cycle as a clear wins
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(sts_wr & t_wdata[4]));
            rx_unf <= rx_unf_set | (rx_unf & ~(sts_wr & t_wdata[5]));
            rx_ovf <= rx_ovf_set | (rx_ovf & ~(sts_wr & t_wdata[6]));
            if (ctrl_wr) ctrl <= t_wdata[2:0];
            ready     <= commit;
            data_read <= (commit && !t_write) ? rdata_c : 32'h0;
            irq       <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty) |
                         (ctrl[2] & (tx_ovf | rx_unf | rx_ovf));
        end
    end

endmodule

// File: tb/tb_bus_mailbox_device.sv
// Self-checking bench for bus_mailbox_device (BASE 0x0001_0000, DEPTH 16,
// WAIT_STATES 1): register vector table plus directed multi-cycle sequences.
module tb_bus_mailbox_device;

    localparam logic [31:0] B = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address, data_write, data_read, tx_data, rx_data;
    logic [3:0]  write_mask;
    logic        ren, wen, ready, active, tx_valid, tx_pop, rx_push, rx_full, irq;

    int vectors     = 0;
    int miscompares = 0;

    bus_mailbox_device #(.BASE_ADDR(B), .DEPTH(16), .WAIT_STATES(1)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_write(data_write),
        .write_mask(write_mask), .ren(ren), .wen(wen), .data_read(data_read),
        .ready(ready), .active(active), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_pop(tx_pop), .rx_push(rx_push), .rx_data(rx_data), .rx_full(rx_full),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        wr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One bus transaction; returns read data and cycles until ready
    task automatic bus_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                           input logic wr, output logic [31:0] rd, output int lat);
        @(negedge clk);
        address = a; data_write = wd; write_mask = m; ren = ~wr; wen = wr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 20);
        rd = data_read;
        if (!ready) check("txn_timeout", 32'(ready), 32'd1);
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic rx_push_word(input logic [31:0] w);
        @(negedge clk);
        rx_data = w; rx_push = 1'b1;
        @(negedge clk);
        rx_push = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    int          n;
    logic        seen;

    initial begin
        tbl = '{
            '{B + 32'h8, 32'h0,          4'h0, 1'b0, 32'h0000_000A},
            '{B + 32'hC, 32'h5,          4'h2, 1'b1, 32'h0},
            '{B + 32'hC, 32'h0,          4'h0, 1'b0, 32'h0},
            '{B + 32'hC, 32'hFFFF_FFFA,  4'h1, 1'b1, 32'h0},
            '{B + 32'hC, 32'h0,          4'h0, 1'b0, 32'h2},
            '{B + 32'hC, 32'h0,          4'hF, 1'b1, 32'h0},
            '{B + 32'h0, 32'hDEAD_BEEF,  4'h5, 1'b1, 32'h0},
            '{B + 32'h8, 32'h0,          4'h0, 1'b0, 32'h0000_0108},
            '{B + 32'h0, 32'h1234_5678,  4'h0, 1'b1, 32'h0},
            '{B + 32'h4, 32'h0000_AAAA,  4'hF, 1'b1, 32'h0},
            '{B + 32'h0, 32'h0,          4'h0, 1'b0, 32'h0},
            '{B + 32'h8, 32'h0,          4'h0, 1'b0, 32'h0000_0108},
            '{B + 32'h4, 32'h0,          4'h0, 1'b0, 32'h0},
            '{B + 32'h8, 32'h0,          4'h0, 1'b0, 32'h0000_0128},
            '{B + 32'h8, 32'h20,         4'h1, 1'b1, 32'h0},
            '{B + 32'h8, 32'h0000_0008,  4'hF, 1'b1, 32'h0},
            '{B + 32'h8, 32'h0,          4'h0, 1'b0, 32'h0000_0108}
        };

        rst_n = 1'b0; address = '0; data_write = '0; write_mask = '0;
        ren = 1'b0; wen = 1'b0; tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data_read", data_read, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_full", 32'(rx_full), 32'd0);
        rst_n = 1'b1;

        // Window decode
        begin
            logic [31:0] addrs [8];
            logic        exps  [8];
            addrs = '{B, B + 32'h4, B + 32'h8, B + 32'hC, B + 32'hF,
                      B - 32'h4, B + 32'h10, 32'h0};
            exps  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < 8; i++) begin
                address = addrs[i];
                #1;
                check($sformatf("active_%h", addrs[i]), 32'(active), 32'(exps[i]));
            end
        end

        // Register vector table
        for (int i = 0; i < 17; i++) begin
            bus_txn(tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].wr, rd, lat);
            check($sformatf("vec%0d_data", i), rd, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // TX head from the masked write, then consume it
        @(negedge clk);
        check("tx_valid_head", 32'(tx_valid), 32'd1);
        check("tx_data_head", tx_data, 32'h00AD_00EF);
        tx_pop = 1'b1;
        @(negedge clk);
        tx_pop = 1'b0;
        check("tx_empty_after_pop", 32'(tx_valid), 32'd0);

        // Fill TX, overflow, clear sticky, drain in order
        for (int i = 0; i < 16; i++) bus_txn(B, 32'h100 + 32'(i), 4'hF, 1'b1, rd, lat);
        bus_txn(B + 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        check("tx_full_status", rd, 32'h0000_1009);
        bus_txn(B, 32'hBAD0_0000, 4'hF, 1'b1, rd, lat);
        check("tx_overflow_ready", 32'(lat), 32'd2);
        bus_txn(B + 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        check("tx_overflow_status", rd, 32'h0000_1019);
        bus_txn(B + 32'h8, 32'h10, 4'hF, 1'b1, rd, lat);
        bus_txn(B + 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        check("tx_overflow_clear", rd, 32'h0000_1009);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_drain%0d", i), tx_data, 32'h100 + 32'(i));
            tx_pop = 1'b1;
            @(negedge clk);
        end
        tx_pop = 1'b0;
        check("tx_drained", 32'(tx_valid), 32'd0);

        // RX: three pushes, four back-to-back reads
        rx_push_word(32'hA000_0001);
        rx_push_word(32'hA000_0002);
        rx_push_word(32'hA000_0003);
        address = B + 32'h4; ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ready && n < 20);
            check($sformatf("rx_b2b%0d", k), data_read,
                  (k < 3) ? 32'hA000_0001 + 32'(k) : 32'h0);
        end
        ren = 1'b0;
        bus_txn(B + 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rx_underflow_status", rd, 32'h0000_002A);
        bus_txn(B + 32'h8, 32'h20, 4'h1, 1'b1, rd, lat);

        // IRQ on RX non-empty
        bus_txn(B + 32'hC, 32'h1, 4'h1, 1'b1, rd, lat);
        @(negedge clk);
        check("irq_idle", 32'(irq), 32'd0);
        rx_data = 32'hC0DE_0001; rx_push = 1'b1;
        @(negedge clk);
        rx_push = 1'b0;
        check("irq_push_edge", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'd1);
        bus_txn(B + 32'h4, 32'h0, 4'h0, 1'b0, rd, lat);
        check("irq_pop_data", rd, 32'hC0DE_0001);
        check("irq_in_resp", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_fall", 32'(irq), 32'd0);

        // IRQ on TX empty
        bus_txn(B + 32'hC, 32'h2, 4'h1, 1'b1, rd, lat);
        @(negedge clk);
        check("irq_tx_empty", 32'(irq), 32'd1);
        bus_txn(B + 32'hC, 32'h0, 4'h1, 1'b1, rd, lat);
        @(negedge clk);
        check("irq_off", 32'(irq), 32'd0);

        // RX overflow: 17 pushes into 16 slots
        for (int i = 0; i < 16; i++) rx_push_word(32'h200 + 32'(i));
        check("rx_full", 32'(rx_full), 32'd1);
        rx_push_word(32'hDEAD_0000);
        bus_txn(B + 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rx_overflow_status", rd, 32'h0010_0046);
        bus_txn(B + 32'h4, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rx_overflow_head", rd, 32'h200);

        // Reset during WAIT: no push, no ready
        @(negedge clk);
        address = B; data_write = 32'h55; write_mask = 4'hF; wen = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready), 32'd0);
        @(negedge clk);
        wen = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_no_push", 32'(tx_valid), 32'd0);

        // Abort by dropping wen in WAIT
        address = B; data_write = 32'h66; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        check("abort_no_push", 32'(tx_valid), 32'd0);
        bus_txn(B + 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        check("abort_status", rd, 32'h0000_000A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_mailbox_device.md
Name: bus_mailbox_device

Overview:
Device-side responder for the shared 32-bit host/device bus; plugs into one device port of the bus hub. It self-decodes a 16-byte address window and drives the active-select back to the hub. Behind the bus it holds two FIFOs: TX (host→peripheral) and RX (peripheral→host). The bus side has register-mapped push/pop, status, control, programmable wait states and an interrupt.

Parameters:
BASE_ADDR, 32'h0001_0000, window base; bits [3:0] ignored.
DEPTH, 16, entries per FIFO; power of 2, 2..128.
WAIT_STATES, 1, idle cycles between request acceptance and ready; 0..15.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
address  in  32  bus address from hub
data_write  in  32  bus write data
write_mask  in  4  byte enables for data_write
ren  in  1  read strobe (gated by hub with active)
wen  in  1  write strobe (gated by hub with active)
data_read  out  32  read data, registered
ready  out  1  transaction-complete pulse, registered
active  out  1  combinational: address[31:4] == BASE_ADDR[31:4]
tx_valid  out  1  TX FIFO non-empty
tx_data  out  32  TX FIFO head word
tx_pop  in  1  peripheral consumes head when tx_valid
rx_push  in  1  peripheral pushes rx_data
rx_data  in  32  word to push
rx_full  out  1  RX FIFO full; a push while full is dropped and sets rx_overflow
irq  out  1  registered interrupt

Behaviour:
- Reset (async, rst_n low):
  - FIFOs empty; sticky flags and CTRL = 0.
  - FSM = IDLE; data_read = 0, ready = 0, irq = 0.
- Register map, word offset address[3:2]:
  - 0 TXDATA: write pushes a word; read returns 0.
  - 1 RXDATA: read pops a word; write is ignored.
  - 2 STATUS: read only, except write-1-to-clear on bits [6:4].
  - 3 CTRL: read/write, bits [2:0].
- STATUS fields:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
  - [4] tx_overflow, [5] rx_underflow, [6] rx_overflow (sticky).
  - [15:8] tx_count, [23:16] rx_count; all other bits 0.
- CTRL fields: [0] irq on rx non-empty, [1] irq on tx empty, [2] irq on any sticky error.
- FSM states: IDLE, WAIT, RESP.
  - IDLE→WAIT when (ren|wen) and active; latch offset, write data and mask. If WAIT_STATES = 0, go directly to RESP.
  - WAIT counts WAIT_STATES cycles, then →RESP.
  - In WAIT, if ren and wen both drop, abort →IDLE with no side effect.
  - RESP lasts exactly one cycle: ready = 1, side effect applied once at that edge, data_read valid. Then →IDLE.
  - data_read is 0 whenever ready = 0.
- Back-to-back transactions: a request still asserted in IDLE after RESP starts a new transaction. Minimum transaction length is WAIT_STATES+1 cycles plus one IDLE cycle.
- ren and wen both high: treated as a write.
- TXDATA write:
  - Pushes only if write_mask != 0; masked-off bytes are stored as 0.
  - If TX is full: no push, tx_overflow set, ready still returned.
- RXDATA read:
  - If RX is empty: returns 0, sets rx_underflow, no pointer change.
- CTRL write honours write_mask byte 0 only.
- Interrupt: irq registered; irq = (CTRL[0] & !rx_empty) | (CTRL[1] & tx_empty) | (CTRL[2] & |STATUS[6:4]).
- FIFO rules:
  - Wrap-around pointers, count width clog2(DEPTH)+1.
  - Simultaneous push and pop on one FIFO: allowed when full (pop frees a slot first) and when empty for TX (push only; head becomes valid next cycle).
  - Status fields reflect post-edge state.
- Reset mid-transaction: immediate return to IDLE, ready = 0, no side effect.

Test Plan:
1. Reset, WAIT_STATES=1: read STATUS at BASE+8 → ready pulses 2 cycles after request, data 32'h0000_000A (tx_empty, rx_empty), active = 1 only for addresses BASE..BASE+0xC.
2. Write 0xDEADBEEF mask 4'b0101 to BASE+0 → tx_valid = 1, tx_data = 0x00AD00EF, tx_count = 1; pulse tx_pop → tx_empty.
3. Fill TX with DEPTH=16 writes, then a 17th → tx_full = 1, STATUS[4] = 1, ready still pulses; write 0x10 to STATUS → bit 4 clears.
4. Push 3 words via rx_push, then 4 back-to-back reads of BASE+4 → first three words in order, fourth returns 0 and sets rx_underflow.
5. CTRL = 1, push one rx word → irq rises the cycle after the push; pop it → irq falls the cycle after RESP.
6. Start a TX write, assert rst_n = 0 during WAIT → no push, ready = 0; also drop wen during WAIT with rst_n high → abort, tx_count unchanged.
